sa2x2_seq_ctrl: RTL and testbench
=================================

Name: sa2x2_seq_ctrl

Overview:
Job sequencer for the 2x2 weight-stationary systolic array: loads a 2x2 weight tile, then streams N activation vectors into the array rows with diagonal skew. It de-skews the column results into an output buffer with valid/ready handshakes, and uses credit-based issue so in-flight results are never dropped (the array has no stall input). It sits between the DMA/stream front-end and the array instance and drives every array input.

Parameters:
DATA_WIDTH, 16, width of weights, activations and results (matches array)
FIFO_DEPTH, 8, result buffer entries (power of 2, >= 4)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-low
start  in  1  pulse: begin job (ignored while busy=1)
cfg_bd  in  2  per-column bd_PE value, latched at start
busy  out  1  high from accepted start until job fully drained into FIFO
w_valid / w_ready  in / out  1 / 1  weight-row handshake
w_0, w_1  in  DATA_WIDTH  weight row (col0, col1)
a_valid / a_ready  in / out  1 / 1  activation handshake
a_0, a_1  in  DATA_WIDTH  activation vector (row0, row1)
a_last  in  1  marks final activation of job
r_valid / r_ready  out / in  1 / 1  result handshake
r_0, r_1  out  DATA_WIDTH  result vector (col0, col1)
r_last  out  1  marks result of the a_last vector
sa_RD_0, sa_RD_1  out  DATA_WIDTH  array row inputs (registered)
sa_FDi_0, sa_FDi_1  out  DATA_WIDTH  array column inputs (registered)
sa_load  out  1  array weight-load strobe (registered)
sa_bd_PE_0, sa_bd_PE_1  out  1  per-column control (registered, = latched cfg_bd)
sa_FDo_0, sa_FDo_1  in  DATA_WIDTH  array column outputs; sa_GD_* left unconnected

Behaviour:
- Reset: state IDLE; busy, w_ready, a_ready, r_valid, r_last, sa_load = 0; all sa_* data and sa_bd_PE = 0; FIFO empty; valid pipeline cleared. Reset mid-job aborts it, with no partial results emitted.
- Array model: each PE hop is one registered cycle; under sa_load=1 PEs capture FDi as weight and pass it down FDo.
- FSM: IDLE -> (start) LOAD_W -> (2nd weight beat) STREAM -> (a_last accepted) DRAIN -> (in-flight = 0) IDLE.
- LOAD_W: w_ready=1. Beat 1 carries row-1 weights, beat 2 carries row-0 weights. A beat accepted in cycle k drives sa_FDi_{0,1}=w_{0,1} and sa_load=1 in cycle k+1. Otherwise sa_load=0 and sa_FDi=0. sa_RD=0 throughout.
- STREAM: a_ready = credit_ok, where credit_ok = (fifo_count + inflight) < FIFO_DEPTH. sa_FDi held 0.
- Issue of a vector accepted in cycle k: sa_RD_0=a_0 in k+1; sa_RD_1=a_1 in k+2 (skew register). Cycles with no accept drive 0.
- Result timing: col0 result on sa_FDo_0 in k+3, col1 on sa_FDo_1 in k+4. The controller delays col0 one cycle and pushes {col0,col1,last} into the FIFO at the end of k+4. r_valid is first possible in k+5, i.e. 5-cycle accept-to-output latency.
- inflight: a 4-stage valid/last shift register; inflight = popcount. Bubbles are never pushed.
- A simultaneous push and pop keeps the count. The credit check makes FIFO overflow impossible; an overflow is an assertion failure.
- r_valid = FIFO non-empty. Pop on r_valid & r_ready; r_last is the stored tag.
- busy drops when DRAIN ends; the FIFO may still hold results.
- A start during busy is ignored. The next job may start while the FIFO drains, and credit accounting persists across jobs.
- N=1 (a_last on first vector) is legal. A w/a handshake outside its state gets ready=0.
- Arithmetic is owned by the PEs; the controller never modifies data.

Decomposition:
- Package sa_ctrl_pkg: FSM state enum (IDLE, LOAD_W, STREAM, DRAIN), PIPE_LAT=4 constant, result-entry struct {r_0, r_1, last}.
- Sub-module sa_res_fifo: synchronous FIFO, FIFO_DEPTH x (2*DATA_WIDTH+1), with count output. All other logic stays in the top module.

Test Plan:
- Load W=[[1,2],[3,4]], stream a=(5,6),(7,8) with a_last on the second, r_ready=1 -> r=(23,34) then (31,46) with r_last; first r_valid exactly 5 cycles after the first accept.
- Check sa_FDi/sa_load during LOAD_W -> cycle k+1 shows (3,4) with load=1, next shows (1,2) with load=1, then load=0.
- Hold r_ready=0 and stream 20 vectors -> a_ready drops once fifo+inflight=8, no result lost; release r_ready -> all 20 results in order.
- Single-vector job (a_last first), then back-to-back second job while the FIFO is non-empty -> correct results for both, r_last once per job.
- Assert rst mid-STREAM with 3 in flight -> all outputs 0 next cycle, FIFO empty; a new job after release gives correct results.
- start pulsed during busy, cfg_bd=2'b10 -> ignored start; sa_bd_PE_1=1, sa_bd_PE_0=0 held for the whole job.

Source files
------------

// File: rtl/sa_ctrl_pkg.sv
// Shared types and constants for the 2x2 systolic-array job sequencer.
package sa_ctrl_pkg;

  localparam int unsigned SA_DW    = 16;
  localparam int unsigned PIPE_LAT = 4;
  localparam int unsigned INF_W    = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [SA_DW-1:0] r_0;
    logic [SA_DW-1:0] r_1;
    logic             last;
  } res_entry_t;

  // Number of valid slots in the result-latency pipeline.
  function automatic logic [INF_W-1:0] popcnt(input logic [PIPE_LAT-1:0] v);
    logic [INF_W-1:0] n;
    n = '0;
    for (int i = 0; i < PIPE_LAT; i++) n = n + INF_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sa_res_fifo.sv
// Result buffer: synchronous FIFO with occupancy count and registered non-empty flag.
module sa_res_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             nempty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             nempty_q;
  logic             pop_ok;

  assign pop_ok  = pop_i & nempty_q;
  assign count_d = count_q + CW'(push_i) - CW'(pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      nempty_q <= 1'b0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_ok) rptr_q <= rptr_q + AW'(1);
      count_q  <= count_d;
      nempty_q <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  // Head is forced to zero while empty so stale entries never reach the port.
  assign rdata_o  = nempty_q ? mem_q[rptr_q] : '0;
  assign nempty_o = nempty_q;
  assign count_o  = count_q;

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_ok && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/sa2x2_seq_ctrl.sv
// Job sequencer for a 2x2 weight-stationary systolic array: weight load, skewed
// activation issue, result de-skew into a credit-protected output FIFO.
module sa2x2_seq_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SA_DW,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cfg_bd,
  output logic                  busy,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_0,
  input  logic [DATA_WIDTH-1:0] w_1,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] a_0,
  input  logic [DATA_WIDTH-1:0] a_1,
  input  logic                  a_last,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_0,
  output logic [DATA_WIDTH-1:0] r_1,
  output logic                  r_last,
  output logic [DATA_WIDTH-1:0] sa_RD_0,
  output logic [DATA_WIDTH-1:0] sa_RD_1,
  output logic [DATA_WIDTH-1:0] sa_FDi_0,
  output logic [DATA_WIDTH-1:0] sa_FDi_1,
  output logic                  sa_load,
  output logic                  sa_bd_PE_0,
  output logic                  sa_bd_PE_1,
  input  logic [DATA_WIDTH-1:0] sa_FDo_0,
  input  logic [DATA_WIDTH-1:0] sa_FDo_1
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = 2 * DATA_WIDTH + 1;

  state_e                state_q, state_d;
  logic                  beat_q, beat_d;
  logic [1:0]            bd_q, bd_d;
  logic                  busy_q, busy_d, w_ready_q, w_ready_d;
  logic                  a_ready_q, a_ready_d, load_q, load_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, skew_q, skew_d;
  logic [DATA_WIDTH-1:0] fdi0_q, fdi0_d, fdi1_q, fdi1_d, col0_q;
  logic [PIPE_LAT-1:0]   vld_q, vld_d, last_q, last_d;
  logic [INF_W-1:0]      inflight_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  w_acc, a_acc, push, pop, r_nempty;
  logic [EW-1:0]         push_data, pop_data;

  assign w_acc     = w_valid & w_ready_q;
  assign a_acc     = a_valid & a_ready_q;
  assign push      = vld_q[PIPE_LAT-1];
  assign pop       = r_nempty & r_ready;
  assign push_data = {col0_q, sa_FDo_1, last_q[PIPE_LAT-1]};

  // Next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    bd_d       = bd_q;
    rd0_d      = a_acc ? a_0 : '0;
    skew_d     = a_acc ? a_1 : '0;
    fdi0_d     = w_acc ? w_0 : '0;
    fdi1_d     = w_acc ? w_1 : '0;
    load_d     = w_acc;
    vld_d      = {vld_q[PIPE_LAT-2:0], a_acc};
    last_d     = {last_q[PIPE_LAT-2:0], a_acc & a_last};
    inflight_d = popcnt(vld_d);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          beat_d  = 1'b0;
          bd_d    = cfg_bd;
        end
      end
      LOAD_W: begin
        if (w_acc) begin
          beat_d = ~beat_q;
          if (beat_q) state_d = STREAM;
        end
      end
      STREAM:  if (a_acc && a_last) state_d = DRAIN;
      DRAIN:   if (vld_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    w_ready_d = (state_d == LOAD_W);
    // Credit computed on next-cycle occupancy so the registered ready is exact.
    a_ready_d = (state_d == STREAM) &&
                ((SW'(cnt_d) + SW'(inflight_d)) < SW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= 1'b0;
      bd_q      <= '0;
      busy_q    <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      load_q    <= 1'b0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      skew_q    <= '0;
      fdi0_q    <= '0;
      fdi1_q    <= '0;
      col0_q    <= '0;
      vld_q     <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      bd_q      <= bd_d;
      busy_q    <= busy_d;
      w_ready_q <= w_ready_d;
      a_ready_q <= a_ready_d;
      load_q    <= load_d;
      rd0_q     <= rd0_d;
      rd1_q     <= skew_q;
      skew_q    <= skew_d;
      fdi0_q    <= fdi0_d;
      fdi1_q    <= fdi1_d;
      col0_q    <= sa_FDo_0;
      vld_q     <= vld_d;
      last_q    <= last_d;
    end
  end

  sa_res_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (pop_data),
    .nempty_o(r_nempty),
    .count_o (cnt_q)
  );

  assign busy       = busy_q;
  assign w_ready    = w_ready_q;
  assign a_ready    = a_ready_q;
  assign r_valid    = r_nempty;
  assign r_0        = pop_data[2*DATA_WIDTH -: DATA_WIDTH];
  assign r_1        = pop_data[DATA_WIDTH -: DATA_WIDTH];
  assign r_last     = pop_data[0];
  assign sa_RD_0    = rd0_q;
  assign sa_RD_1    = rd1_q;
  assign sa_FDi_0   = fdi0_q;
  assign sa_FDi_1   = fdi1_q;
  assign sa_load    = load_q;
  assign sa_bd_PE_0 = bd_q[0];
  assign sa_bd_PE_1 = bd_q[1];

endmodule

// File: tb/tb_sa2x2_seq_ctrl.sv
// Directed bench for sa2x2_seq_ctrl with a behavioural 2x2 weight-stationary array.
module tb_sa2x2_seq_ctrl;
  import sa_ctrl_pkg::*;

  logic        clk, rst, start, busy;
  logic [1:0]  cfg_bd;
  logic        w_valid, w_ready, a_valid, a_ready, a_last;
  logic        r_valid, r_ready, r_last, sa_load, sa_bd_PE_0, sa_bd_PE_1;
  logic [15:0] w_0, w_1, a_0, a_1, r_0, r_1;
  logic [15:0] sa_RD_0, sa_RD_1, sa_FDi_0, sa_FDi_1, sa_FDo_0, sa_FDo_1;

  int total = 0;
  int bad   = 0;
  int sent, rcv;
  logic acc;
  res_entry_t e;

  sa2x2_seq_ctrl #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_bd(cfg_bd), .busy(busy),
    .w_valid(w_valid), .w_ready(w_ready), .w_0(w_0), .w_1(w_1),
    .a_valid(a_valid), .a_ready(a_ready), .a_0(a_0), .a_1(a_1), .a_last(a_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_0(r_0), .r_1(r_1), .r_last(r_last),
    .sa_RD_0(sa_RD_0), .sa_RD_1(sa_RD_1), .sa_FDi_0(sa_FDi_0), .sa_FDi_1(sa_FDi_1),
    .sa_load(sa_load), .sa_bd_PE_0(sa_bd_PE_0), .sa_bd_PE_1(sa_bd_PE_1),
    .sa_FDo_0(sa_FDo_0), .sa_FDo_1(sa_FDo_1)
  );

  // Array model: PE(r,c) passes activations right and partial sums down, one hop per cycle.
  logic [15:0] w00, w01, w10, w11, fd00, fd01, fd10, fd11, rd00, rd10;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {w00, w01, w10, w11, fd00, fd01, fd10, fd11, rd00, rd10} <= '0;
    end else begin
      rd00 <= sa_RD_0;
      rd10 <= sa_RD_1;
      if (sa_load) begin
        w00 <= sa_FDi_0; fd00 <= sa_FDi_0;
        w01 <= sa_FDi_1; fd01 <= sa_FDi_1;
        w10 <= fd00;     fd10 <= fd00;
        w11 <= fd01;     fd11 <= fd01;
      end else begin
        fd00 <= sa_FDi_0 + sa_RD_0 * w00;
        fd01 <= sa_FDi_1 + rd00 * w01;
        fd10 <= fd00 + sa_RD_1 * w10;
        fd11 <= fd01 + rd10 * w11;
      end
    end
  end
  assign sa_FDo_0 = fd10;
  assign sa_FDo_1 = fd11;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [1:0] bd);
    cfg_bd = bd; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Beat 1 carries row-1 weights, beat 2 row-0 weights.
  task automatic load_w(input logic [15:0] r1c0, r1c1, r0c0, r0c1);
    chk("w_ready_at_load", 64'(w_ready), 64'd1);
    w_valid = 1'b1; w_0 = r1c0; w_1 = r1c1;
    tick();
    w_0 = r0c0; w_1 = r0c1;
    tick();
    w_valid = 1'b0; w_0 = '0; w_1 = '0;
  endtask

  task automatic send_a(input logic [15:0] x0, x1, input logic last);
    a_valid = 1'b1; a_0 = x0; a_1 = x1; a_last = last;
    for (int n = 0; n < 40; n++) begin
      if (a_ready) break;
      tick();
    end
    chk("a_ready_wait", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic get_r(input string tag, input logic [15:0] x0, x1, input logic last);
    for (int n = 0; n < 40; n++) begin
      if (r_valid) break;
      tick();
    end
    chk(tag, 64'({r_valid, r_0, r_1, r_last}), 64'({1'b1, x0, x1, last}));
    tick();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cfg_bd = '0; w_valid = 1'b0; w_0 = '0; w_1 = '0;
    a_valid = 1'b0; a_0 = '0; a_1 = '0; a_last = 1'b0; r_ready = 1'b0;
    tick(); tick();
    chk("reset_ctrl", 64'({busy, w_ready, a_ready, r_valid, r_last, sa_load}), 64'd0);
    chk("reset_data", 64'({sa_RD_0, sa_RD_1, sa_FDi_0, sa_FDi_1, sa_bd_PE_1, sa_bd_PE_0}), 64'd0);
    rst = 1'b1;
    tick();

    // Basic job with exact cycle checks, ignored start and cfg_bd=10.
    r_ready = 1'b1;
    start_job(2'b10);
    chk("A_busy_wready", 64'({busy, w_ready}), 64'b11);
    chk("A_bd_start", 64'({sa_bd_PE_1, sa_bd_PE_0}), 64'b10);
    w_valid = 1'b1; w_0 = 16'd3; w_1 = 16'd4;
    tick();
    chk("A_load_beat1", 64'({sa_FDi_0, sa_FDi_1, sa_load}), 64'({16'd3, 16'd4, 1'b1}));
    w_0 = 16'd1; w_1 = 16'd2;
    tick();
    chk("A_load_beat2", 64'({sa_FDi_0, sa_FDi_1, sa_load}), 64'({16'd1, 16'd2, 1'b1}));
    w_valid = 1'b0;
    tick();
    chk("A_load_done", 64'({sa_FDi_0, sa_FDi_1, sa_load, w_ready}), 64'd0);
    chk("A_a_ready", 64'(a_ready), 64'd1);
    a_valid = 1'b1; a_0 = 16'd5; a_1 = 16'd6; start = 1'b1; cfg_bd = 2'b01;
    tick();
    start = 1'b0;
    chk("A_rd0_k1", 64'(sa_RD_0), 64'd5);
    chk("A_start_ignored", 64'(w_ready), 64'd0);
    a_0 = 16'd7; a_1 = 16'd8; a_last = 1'b1;
    tick();
    a_valid = 1'b0; a_last = 1'b0;
    chk("A_rd_k2", 64'({sa_RD_0, sa_RD_1}), 64'({16'd7, 16'd6}));
    chk("A_a_ready_drain", 64'(a_ready), 64'd0);
    tick();
    chk("A_rd_k3", 64'({sa_RD_0, sa_RD_1}), 64'({16'd0, 16'd8}));
    tick();
    chk("A_rvalid_k4", 64'(r_valid), 64'd0);
    tick();
    chk("A_res0_k5", 64'({r_valid, r_0, r_1, r_last}), 64'({1'b1, 16'd23, 16'd34, 1'b0}));
    chk("A_bd_busy_k5", 64'({busy, sa_bd_PE_1, sa_bd_PE_0}), 64'b110);
    tick();
    chk("A_res1", 64'({r_valid, r_0, r_1, r_last}), 64'({1'b1, 16'd31, 16'd46, 1'b1}));
    chk("A_busy_done", 64'(busy), 64'd0);
    tick();
    chk("A_empty", 64'(r_valid), 64'd0);

    // Backpressure: 20 vectors with r_ready low, credit caps occupancy at 8.
    r_ready = 1'b0; sent = 0; rcv = 0;
    start_job(2'b00);
    load_w(16'd3, 16'd4, 16'd1, 16'd2);
    for (int n = 0; n < 30; n++) begin
      a_valid = 1'b1; a_0 = 16'(sent + 1); a_1 = 16'(sent + 2); a_last = (sent == 19);
      acc = a_ready;
      tick();
      if (acc) sent++;
    end
    chk("B_accepted_cap", 64'(sent), 64'd8);
    chk("B_stalled", 64'({a_ready, r_valid}), 64'b01);
    r_ready = 1'b1;
    for (int n = 0; n < 400 && rcv < 20; n++) begin
      if (sent < 20) begin
        a_valid = 1'b1; a_0 = 16'(sent + 1); a_1 = 16'(sent + 2); a_last = (sent == 19);
      end else begin
        a_valid = 1'b0; a_last = 1'b0;
      end
      acc = a_valid && a_ready;
      if (r_valid) begin
        e.r_0  = 16'((rcv + 1) + 3 * (rcv + 2));
        e.r_1  = 16'(2 * (rcv + 1) + 4 * (rcv + 2));
        e.last = (rcv == 19);
        chk("B_result", 64'({r_0, r_1, r_last}), 64'(e));
        rcv++;
      end
      tick();
      if (acc) sent++;
    end
    a_valid = 1'b0; a_last = 1'b0;
    chk("B_count", 64'(rcv), 64'd20);
    tick();
    chk("B_idle", 64'({busy, r_valid}), 64'd0);

    // Single-vector job, then a second job while its result waits in the FIFO.
    r_ready = 1'b0;
    start_job(2'b00);
    load_w(16'd3, 16'd4, 16'd1, 16'd2);
    send_a(16'd2, 16'd3, 1'b1);
    for (int n = 0; n < 30; n++) begin
      if (!busy) break;
      tick();
    end
    chk("C_job1_held", 64'({busy, r_valid}), 64'b01);
    start_job(2'b00);
    load_w(16'd0, 16'd1, 16'd1, 16'd0);
    send_a(16'd9, 16'd10, 1'b0);
    send_a(16'd11, 16'd12, 1'b1);
    r_ready = 1'b1;
    get_r("C_job1_res", 16'd11, 16'd16, 1'b1);
    get_r("C_job2_res0", 16'd9, 16'd10, 1'b0);
    get_r("C_job2_res1", 16'd11, 16'd12, 1'b1);
    chk("C_empty", 64'(r_valid), 64'd0);

    // Reset with three vectors in flight, then a clean job.
    start_job(2'b11);
    load_w(16'd3, 16'd4, 16'd1, 16'd2);
    send_a(16'd1, 16'd2, 1'b0);
    send_a(16'd1, 16'd2, 1'b0);
    send_a(16'd1, 16'd2, 1'b0);
    rst = 1'b0;
    tick();
    chk("D_rst_ctrl", 64'({busy, w_ready, a_ready, r_valid, r_last, sa_load}), 64'd0);
    chk("D_rst_data", 64'({sa_RD_0, sa_RD_1, sa_FDi_0, sa_FDi_1, sa_bd_PE_1, sa_bd_PE_0}), 64'd0);
    tick();
    rst = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    chk("D_no_partial", 64'({busy, r_valid}), 64'd0);
    start_job(2'b00);
    load_w(16'd3, 16'd4, 16'd1, 16'd2);
    send_a(16'd1, 16'd1, 1'b1);
    get_r("D_after_reset", 16'd4, 16'd6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
